// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - initial_bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             initial_bin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow;
  logic             borrow_nxt;
  logic             d;
  logic             last_bit;
  logic [CW-1:0]    cnt;

  // Result register keeps only WIDTH-1 bits; the final bit goes straight to diff_out.
  always_comb begin
    d          = a_sr[0] ^ b_sr[0] ^ borrow;
    borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    res_nxt    = {d, res_sr};
    last_bit   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      diff_out <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= initial_bin;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= borrow_nxt;
          res_sr <= res_nxt[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            diff_out <= {borrow_nxt, res_nxt};
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit a_sr[0]/b_sr[0] hold the captured operand MSBs.
            ovf      <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: timestamp-based reference model, directed and random ops.
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W:0]   diff_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .initial_bin(bin),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: an op accepted at edge acc is busy through edge acc+W,
  // finishes (done, result) at edge acc+W, and a new start is accepted only from acc+W+2.
  longint       cyc = 0;
  longint       acc = 0;
  bit           active = 0;
  bit           m_valid = 0;
  logic [W-1:0] cap_a, cap_b;
  logic         cap_bin;
  logic [W:0]   m_diff = '0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin
    int sd;
    cyc++;
    if (rst) begin
      active  = 0;
      m_diff  = '0;
      m_ovf   = 1'b0;
      m_valid = 1;
    end else begin
      if (active && (cyc - acc) == W) begin
        m_diff = {1'b0, cap_a} - {1'b0, cap_b} - {{W{1'b0}}, cap_bin};
        sd     = int'($signed(cap_a)) - int'($signed(cap_b)) - int'(cap_bin);
        m_ovf  = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
      end
      if ((!active || (cyc - acc) >= W + 2) && start) begin
        active  = 1;
        acc     = cyc;
        cap_a   = a;
        cap_b   = b;
        cap_bin = bin;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, (active && (cyc - acc) <= W) ? 1'b1 : 1'b0});
      chk("done", {31'b0, done}, {31'b0, (active && (cyc - acc) == W) ? 1'b1 : 1'b0});
      chk("diff_out", 32'(diff_out), 32'(m_diff));
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
`endif
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                    input logic [W:0] exp_d, input string nm, input bit hold);
    int lat = 0;
    wait_idle();
    @(posedge clk); #1;
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a = ~ta; b = ~tb_; bin = ~tbin;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 4) a = ta ^ 8'h5A;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(W + 1));
    chk(nm, 32'(diff_out), 32'(exp_d));
    @(negedge clk);
    chk({nm, "_busy_after"}, {31'b0, busy}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_diff", 32'(diff_out), 32'd0);

    op(8'd200, 8'd55, 1'b0, 9'h091, "sub_200_55", 0);
    op(8'd10,  8'd20, 1'b0, 9'h1F6, "sub_10_20", 0);
    op(8'd5,   8'd5,  1'b1, 9'h1FF, "sub_5_5_bin", 0);
    op(8'd0,   8'd0,  1'b0, 9'h000, "sub_0_0", 0);
`ifdef SERIAL_SUB_OVF_EN
    op(8'h80, 8'h01, 1'b0, 9'h07F, "ovf_80_01", 0);
    chk("ovf_80_01_flag", {31'b0, ovf}, 32'd1);
    op(8'h7F, 8'h01, 1'b0, 9'h07E, "ovf_7f_01", 0);
    chk("ovf_7f_01_flag", {31'b0, ovf}, 32'd0);
`endif
    op(8'd100, 8'd30, 1'b1, 9'h045, "held_start", 1);
    op(8'd200, 8'd55, 1'b0, 9'h091, "pre_abort", 0);

    // Abort during the fourth SHIFT cycle.
    wait_idle();
    @(posedge clk); #1;
    a = 8'd77; b = 8'd11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_diff", 32'(diff_out), 32'd0);
    op(8'd3, 8'd1, 1'b0, 9'h002, "after_abort", 0);

    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: a = '0;
        1: a = '1;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = '1;
        default: b = W'($urandom);
      endcase
      bin = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
